// File: rtl/out_serializer_pkg.sv
// Shared accelerator definitions: default array geometry, FIFO operation
// encoding and a clog2-based width helper used by the output serializer.
package out_serializer_pkg;

    localparam int unsigned ACC_COL     = 32'd8;
    localparam int unsigned ACC_PSUM_BW = 32'd16;
    localparam int unsigned ACC_DEPTH   = 32'd4;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/out_serializer_sync_fifo.sv
// Synchronous FIFO holding whole psum vectors for the output serializer.
// Push is refused while full and pop while empty, using the count at cycle start.
module sync_fifo
    import out_serializer_pkg::*;
#(
    parameter int unsigned width = ACC_COL * ACC_PSUM_BW,
    parameter int unsigned depth = ACC_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [width-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = clog2_w(depth);
    localparam int unsigned CNT_W = clog2_w(depth + 32'd1);

    logic [width-1:0] r_mem [depth];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;
    fifo_op_e         w_op;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 32'd1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(depth));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];

    // Classify this cycle's accepted operations.
    always_comb begin
        w_op = fifo_op_e'({w_do_pop, w_do_push});
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            case (w_op)
                FIFO_PUSH: begin
                    r_wptr  <= ptr_inc(r_wptr);
                    r_count <= r_count + CNT_W'(1);
                end
                FIFO_POP: begin
                    r_rptr  <= ptr_inc(r_rptr);
                    r_count <= r_count - CNT_W'(1);
                end
                FIFO_BOTH: begin
                    r_wptr <= ptr_inc(r_wptr);
                    r_rptr <= ptr_inc(r_rptr);
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // Vector storage; contents are left as-is on reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/out_serializer.sv
// Buffers core output vectors and emits them one signed psum column per transfer.
// Optional OUT_SERIALIZER_RELU_EN clamps negative columns to zero on FIFO write.
module out_serializer
    import out_serializer_pkg::*;
#(
    parameter int unsigned col     = ACC_COL,
    parameter int unsigned psum_bw = ACC_PSUM_BW,
    parameter int unsigned depth   = ACC_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [psum_bw*col-1:0]     in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [psum_bw-1:0]         out_data,
    output logic [clog2_w(col)-1:0]    out_col,
    output logic                       out_last
);

    localparam int unsigned COL_W = clog2_w(col);
    localparam int unsigned VEC_W = psum_bw * col;

    logic [COL_W-1:0]   r_col;
    logic [VEC_W-1:0]   w_wdata;
    logic [VEC_W-1:0]   w_rdata;
    logic [psum_bw-1:0] w_word;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_xfer;
    logic               w_at_last;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;
    assign w_at_last = (r_col == COL_W'(col - 32'd1));
    assign w_pop     = w_xfer && w_at_last;

    // Write-side column conditioning.
    always_comb begin
        w_wdata = in_data;
`ifdef OUT_SERIALIZER_RELU_EN
        for (int c = 0; c < int'(col); c++) begin
            if (in_data[c*psum_bw + psum_bw - 1]) begin
                w_wdata[c*psum_bw +: psum_bw] = {psum_bw{1'b0}};
            end else begin
                w_wdata[c*psum_bw +: psum_bw] = in_data[c*psum_bw +: psum_bw];
            end
        end
`endif
    end

    sync_fifo #(
        .width (VEC_W),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Select the current column of the head vector.
    always_comb begin
        w_word = {psum_bw{1'b0}};
        for (int c = 0; c < int'(col); c++) begin
            if (r_col == COL_W'(c)) begin
                w_word = w_rdata[c*psum_bw +: psum_bw];
            end else begin
                w_word = w_word;
            end
        end
    end

    // Output presentation, forced quiet whenever nothing is queued.
    always_comb begin
        if (out_valid) begin
            out_data = w_word;
            out_col  = r_col;
            out_last = w_at_last;
        end else begin
            out_data = {psum_bw{1'b0}};
            out_col  = {COL_W{1'b0}};
            out_last = 1'b0;
        end
    end

    // Column cursor: advances per accepted word, wraps when the head is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= {COL_W{1'b0}};
        end else if (w_xfer) begin
            if (w_at_last) begin
                r_col <= {COL_W{1'b0}};
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end else begin
            r_col <= r_col;
        end
    end

endmodule

// File: tb/tb_out_serializer.sv
// Self-checking bench for out_serializer: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_out_serializer;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int VW    = COL * BW;
`ifdef OUT_SERIALIZER_RELU_EN
    localparam logic [15:0] NEG_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG_EXP = 16'hFFF6;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [VW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [2:0]    out_col;
    logic          out_last;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    out_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input logic [15:0] base);
        logic [VW-1:0] v;
        for (int c = 0; c < COL; c++) v[c*BW +: BW] = base + 16'(c);
        return v;
    endfunction

    function automatic logic [VW-1:0] model_store(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef OUT_SERIALIZER_RELU_EN
        for (int c = 0; c < COL; c++) if (v[c*BW + BW - 1]) r[c*BW +: BW] = 16'h0000;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of vectors plus column cursor, checked each negedge,
    // then advanced by what the coming rising edge will do with current inputs.
    initial begin : cmp
        logic [VW-1:0] q[$];
        logic [VW-1:0] head;
        int            mcol;
        bit            ok;
        bit            hold;
        logic [15:0]   pd;
        logic [2:0]    pc;
        logic [15:0]   exp_d;
        bit            ev;
        bit            do_pop;
        bit            do_push;
        mcol = 0;
        ok   = 1'b0;
        hold = 1'b0;
        pd   = 16'h0;
        pc   = 3'd0;
        forever begin
            @(negedge clk);
            if (ok) begin
                ev    = (q.size() != 0);
                head  = ev ? q[0] : '0;
                exp_d = ev ? head[mcol*BW +: BW] : 16'h0000;
                check("m_out_valid", 32'(out_valid), 32'(ev));
                check("m_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
                check("m_out_data", 32'(out_data), 32'(exp_d));
                check("m_out_col", 32'(out_col), ev ? 32'(mcol) : 32'd0);
                check("m_out_last", 32'(out_last), 32'(ev && (mcol == COL - 1)));
                if (hold) begin
                    check("hold_data", 32'(out_data), 32'(pd));
                    check("hold_col", 32'(out_col), 32'(pc));
                end
            end
            hold = ok && out_valid && !out_ready && !reset;
            pd   = out_data;
            pc   = out_col;
            if (reset) begin
                q.delete();
                mcol = 0;
                ok   = 1'b1;
            end else if (ok) begin
                do_pop  = (q.size() != 0) && out_ready && (mcol == COL - 1);
                do_push = in_valid && (q.size() != DEPTH);
                if ((q.size() != 0) && out_ready) mcol = do_pop ? 0 : mcol + 1;
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(model_store(in_data));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [VW-1:0] v;
        bit            drained;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);

        // One vector 1..8 streamed with sink always ready.
        tick();
        in_valid  = 1'b1;
        in_data   = mkvec(16'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_data", 32'(out_data), 32'(k));
            check("t1_last", 32'(out_last), 32'(k == 8));
        end
        @(negedge clk);
        check("t1_valid_fall", 32'(out_valid), 32'd0);

        // Fill while sink stalled: 5 offered, 4 accepted, then drain 32 words.
        tick();
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_data  = mkvec(16'(16'h100 * (n + 1)));
            @(negedge clk);
            check("t2_in_ready", 32'(in_ready), 32'(n < 4));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < COL; c++) begin
                @(negedge clk);
                check("t2_data", 32'(out_data), 32'(16'h100 * (n + 1) + c));
                check("t2_col", 32'(out_col), 32'(c));
            end
        end
        @(negedge clk);
        check("t2_empty", 32'(out_valid), 32'd0);

        // Random backpressure and random offers; model checks order and stability.
        for (int i = 0; i < 300; i++) begin
            tick();
            in_valid  = 1'($urandom_range(1, 0));
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = 1'($urandom_range(1, 0));
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drained   = 1'b0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            if (!out_valid) drained = 1'b1;
        end
        check("t3_drain", 32'(drained), 32'd1);

        // Negative column 3.
        tick();
        v = mkvec(16'h0020);
        v[3*BW +: BW] = 16'hFFF6;
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < COL; c++) begin
            @(negedge clk);
            check("t4_data", 32'(out_data), (c == 3) ? 32'(NEG_EXP) : 32'(16'h20 + c));
        end

        // Reset mid-vector with two vectors queued.
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mkvec(16'h0300);
        tick();
        in_data = mkvec(16'h0400);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_col5", 32'(out_col), 32'd5);
        check("t5_data5", 32'(out_data), 32'h305);
        tick();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = mkvec(16'h0500);
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b1;
        in_data  = mkvec(16'h0600);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_new_col", 32'(out_col), 32'd0);
        check("t5_new_data", 32'(out_data), 32'h600);
        tick();
        out_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("t5_drain", 32'(out_valid), 32'd0);

        // Push coinciding with last-column pop at count 2, across pointer wrap.
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mkvec(16'h0700);
        tick();
        in_data = mkvec(16'h0800);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (7) tick();
            in_valid = 1'b1;
            in_data  = mkvec(16'(16'h900 + 16'h100 * k));
            @(negedge clk);
            check("t6_in_ready", 32'(in_ready), 32'd1);
            check("t6_last", 32'(out_last), 32'd1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("t6_col0", 32'(out_col), 32'd0);
            check("t6_head", 32'(out_data), 32'(16'h800 + 16'h100 * k));
        end
        repeat (16) tick();
        @(negedge clk);
        check("t6_drain", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
